// File: rtl/usb_reset_sequencer.sv
// ---------------------------------------------------------------------------
// usb_reset_sequencer
//   Turns the software reset level from the USB reset PIO into a timed,
//   glitch-free active-low reset for the external USB controller. Holds the
//   reset for a minimum width, waits a settle window after release, and
//   reports busy/ready back to software. A full sequence also runs after
//   system reset.
//
// Ports
//   clk        system clock (single domain)
//   reset      asynchronous active-high reset
//   req_in     reset request level from the PIO (may be asynchronous)
//   usb_rst_n  registered active-low reset to the USB chip
//   busy       1 while asserting reset or settling
//   ready      1 once the settle window has elapsed
//   rst_count  saturating count of software-requested sequences
// ---------------------------------------------------------------------------
module usb_reset_sequencer #(
   parameter int unsigned ASSERT_CYCLES = 500000,
   parameter int unsigned SETTLE_CYCLES = 2500000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req_in,
   output logic       usb_rst_n,
   output logic       busy,
   output logic       ready,
   output logic [7:0] rst_count
);

   localparam int unsigned MAX_CYCLES = (ASSERT_CYCLES > SETTLE_CYCLES) ? ASSERT_CYCLES : SETTLE_CYCLES;
   localparam int unsigned CNT_W      = $clog2(MAX_CYCLES);
   localparam logic [CNT_W-1:0] ASSERT_LAST = CNT_W'(ASSERT_CYCLES - 1);
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_ASSERT = 2'd0,
      ST_SETTLE = 2'd1,
      ST_READY  = 2'd2
   } state_t;

   state_t           state, state_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic             s1, s2, s3;
   logic             rise;
   logic [7:0]       count_nx;
   logic             usb_rst_n_nx, busy_nx, ready_nx;

   // s1/s2 resynchronise the request; s3 delays s2 for rising-edge detection
   assign rise = s2 & ~s3;

   // State, counter, synchroniser and output registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= ST_ASSERT;
         cnt       <= '0;
         s1        <= 1'b0;
         s2        <= 1'b0;
         s3        <= 1'b0;
         usb_rst_n <= 1'b0;
         busy      <= 1'b1;
         ready     <= 1'b0;
         rst_count <= 8'd0;
      end else begin
         state     <= state_nx;
         cnt       <= cnt_nx;
         s1        <= req_in;
         s2        <= s1;
         s3        <= s2;
         usb_rst_n <= usb_rst_n_nx;
         busy      <= busy_nx;
         ready     <= ready_nx;
         rst_count <= count_nx;
      end
   end

   // Next-state, counter and next-output logic
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      count_nx = rst_count;

      if (rise) begin
         // A new request always restarts the full assert width
         state_nx = ST_ASSERT;
         cnt_nx   = '0;
         if (rst_count != 8'hFF) begin
            count_nx = rst_count + 8'd1;
         end
      end else begin
         case (state)
            ST_ASSERT: begin
               if (cnt == ASSERT_LAST) begin
                  // Software still holding the level extends the reset
                  if (!s2) begin
                     state_nx = ST_SETTLE;
                     cnt_nx   = '0;
                  end
               end else begin
                  cnt_nx = cnt + CNT_W'(1);
               end
            end
            ST_SETTLE: begin
               if (cnt == SETTLE_LAST) begin
                  state_nx = ST_READY;
                  cnt_nx   = '0;
               end else begin
                  cnt_nx = cnt + CNT_W'(1);
               end
            end
            ST_READY: begin
               state_nx = ST_READY;
            end
            default: begin
               state_nx = ST_ASSERT;
               cnt_nx   = '0;
            end
         endcase
      end

      // Outputs follow the next state so they change on the same edge
      usb_rst_n_nx = (state_nx != ST_ASSERT);
      busy_nx      = (state_nx != ST_READY);
      ready_nx     = (state_nx == ST_READY);
   end

endmodule

// File: tb/tb_usb_reset_sequencer.sv
// ---------------------------------------------------------------------------
// tb_usb_reset_sequencer
//   Drives scripted and random request levels into usb_reset_sequencer
//   (ASSERT_CYCLES=4, SETTLE_CYCLES=6) and compares every cycle against a
//   timestamp-based reference: each sequence has a start edge, a release
//   edge, and ready follows release by the settle time.
// ---------------------------------------------------------------------------
module tb_usb_reset_sequencer;

   localparam int A = 4;
   localparam int S = 6;
   localparam int HMAX = 16384;

   logic       clk;
   logic       reset;
   logic       req_in;
   logic       usb_rst_n;
   logic       busy;
   logic       ready;
   logic [7:0] rst_count;
   logic [10:0] obs;

   int vectors;
   int miscompares;

   // Reference model state: edge index, start of current assert, release edge
   int  n;
   int  start_e;
   int  rel_e;
   int  req_cnt;
   bit  hist [0:HMAX-1];

   usb_reset_sequencer #(
      .ASSERT_CYCLES(A),
      .SETTLE_CYCLES(S)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .req_in   (req_in),
      .usb_rst_n(usb_rst_n),
      .busy     (busy),
      .ready    (ready),
      .rst_count(rst_count)
   );

   assign obs = {usb_rst_n, busy, ready, rst_count};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Request level sampled at edge i (zero before the first edge after reset)
   function automatic bit h(input int i);
      if (i >= 1 && i < HMAX) return hist[i];
      return 1'b0;
   endfunction

   function automatic logic [10:0] exp_vec();
      bit released;
      bit rdy;
      released = (rel_e >= 0);
      rdy      = released && (n >= rel_e + S);
      return {released, ~rdy, rdy, 8'(req_cnt)};
   endfunction

   task automatic model_clear();
      n       = 0;
      start_e = 0;
      rel_e   = -1;
      req_cnt = 0;
   endtask

   // Apply one request level across one clock edge and advance the model
   task automatic step(input bit r);
      req_in = r;
      @(posedge clk);
      n = n + 1;
      if (n < HMAX) hist[n] = r;
      if (h(n - 2) && !h(n - 3)) begin
         start_e = n;
         rel_e   = -1;
         if (req_cnt < 255) req_cnt = req_cnt + 1;
      end else if (rel_e < 0 && n >= start_e + A && !h(n - 2)) begin
         rel_e = n;
      end
      #1;
   endtask

   task automatic test_reset();
      vectors++;
      if (obs !== 11'b0_1_0_00000000) begin
         miscompares++;
         $display("FAIL reset_values got %b expected %b", obs, 11'b0_1_0_00000000);
      end
   endtask

   task automatic test_power_on();
      for (int c = 0; c < 14; c++) begin
         step(1'b0);
         vectors++;
         if (obs !== exp_vec()) begin
            miscompares++;
            $display("FAIL power_on cycle %0d got %b expected %b", c, obs, exp_vec());
         end
      end
   endtask

   task automatic test_pulse();
      for (int c = 0; c < 16; c++) begin
         step(c < 2);
         vectors++;
         if (obs !== exp_vec()) begin
            miscompares++;
            $display("FAIL pulse cycle %0d got %b expected %b", c, obs, exp_vec());
         end
      end
   endtask

   task automatic test_hold();
      for (int c = 0; c < 32; c++) begin
         step(c < 20);
         vectors++;
         if (obs !== exp_vec()) begin
            miscompares++;
            $display("FAIL hold cycle %0d got %b expected %b", c, obs, exp_vec());
         end
      end
   endtask

   task automatic test_repulse();
      // Second pulse is timed to land in the settle window of the first
      for (int c = 0; c < 26; c++) begin
         step((c < 2) || (c == 7) || (c == 8));
         vectors++;
         if (obs !== exp_vec()) begin
            miscompares++;
            $display("FAIL repulse cycle %0d got %b expected %b", c, obs, exp_vec());
         end
      end
   endtask

   task automatic test_saturate();
      for (int p = 0; p < 260; p++) begin
         for (int c = 0; c < 14; c++) begin
            step(c < 2);
            vectors++;
            if (obs !== exp_vec()) begin
               miscompares++;
               $display("FAIL saturate req %0d cycle %0d got %b expected %b", p, c, obs, exp_vec());
            end
         end
      end
      vectors++;
      if (rst_count !== 8'd255) begin
         miscompares++;
         $display("FAIL saturate_final got %0d expected 255", rst_count);
      end
   endtask

   task automatic test_random();
      bit lvl;
      int len;
      lvl = 1'b0;
      for (int seg = 0; seg < 80; seg++) begin
         lvl = ~lvl;
         len = $urandom_range(12, 2);
         for (int c = 0; c < len; c++) begin
            step(lvl);
            vectors++;
            if (obs !== exp_vec()) begin
               miscompares++;
               $display("FAIL random seg %0d cycle %0d got %b expected %b", seg, c, obs, exp_vec());
            end
         end
      end
      for (int c = 0; c < 16; c++) begin
         step(1'b0);
         vectors++;
         if (obs !== exp_vec()) begin
            miscompares++;
            $display("FAIL random_drain cycle %0d got %b expected %b", c, obs, exp_vec());
         end
      end
   endtask

   task automatic test_mid_reset();
      // Request a sequence, advance into the settle window, then hit reset
      for (int c = 0; c < 9; c++) step(c < 2);
      vectors++;
      if ({usb_rst_n, busy, ready} !== 3'b110) begin
         miscompares++;
         $display("FAIL mid_reset_in_settle got %b expected 110", {usb_rst_n, busy, ready});
      end
      reset = 1'b1;
      #1;
      vectors++;
      if (obs !== 11'b0_1_0_00000000) begin
         miscompares++;
         $display("FAIL mid_reset_async got %b expected %b", obs, 11'b0_1_0_00000000);
      end
      @(negedge clk);
      reset = 1'b0;
      model_clear();
      for (int c = 0; c < 14; c++) begin
         step(1'b0);
         vectors++;
         if (obs !== exp_vec()) begin
            miscompares++;
            $display("FAIL mid_reset_rerun cycle %0d got %b expected %b", c, obs, exp_vec());
         end
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      reset       = 1'b1;
      req_in      = 1'b0;
      model_clear();
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      @(negedge clk);
      reset = 1'b0;
      test_power_on();
      test_pulse();
      test_hold();
      test_repulse();
      test_random();
      test_saturate();
      test_mid_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
